data_mem_bridge: RTL and testbench

Memory-stage load/store unit. It sits between the datapath's M stage (opM, aluoutM, writedataM, readdataM, adel_rdM/adesM) and an SRAM-like data bus with a req/addr_ok/data_ok handshake. It performs alignment checks, byte-lane steering and load extension, and runs a multi-cycle bus transaction. While a transaction is outstanding it asserts stallM to the hazard unit.

---
 rtl/data_mem_bridge_pkg.sv | 37 +++
 rtl/data_mem_bridge_mem_load_ext.sv | 31 +++
 rtl/data_mem_bridge.sv | 157 +++++++++++++++
 tb/tb_data_mem_bridge.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_bridge_pkg.sv
// rtl/data_mem_bridge_pkg.sv - memory opcodes, bus size codes and FSM states for the M-stage bridge
package data_mem_bridge_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} memState_t;

  function automatic logic isLoadOp(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic isStoreOp(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Non-memory opcodes fall into the word bucket; callers gate with isLoadOp/isStoreOp.
  function automatic logic [1:0] opSize(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_bridge_mem_load_ext.sv
// rtl/data_mem_bridge_mem_load_ext.sv - selects the addressed byte/half of a read word and sign/zero extends it
module mem_load_ext
  import data_mem_bridge_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addrLo,
  input  logic [31:0] rdata,
  output logic [31:0] extData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  always_comb begin
    case (addrLo)
      2'd0:    byteSel = rdata[7:0];
      2'd1:    byteSel = rdata[15:8];
      2'd2:    byteSel = rdata[23:16];
      default: byteSel = rdata[31:24];
    endcase
    halfSel = addrLo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   extData = {{24{byteSel[7]}}, byteSel};
      OP_LBU:  extData = {24'h0, byteSel};
      OP_LH:   extData = {{16{halfSel[15]}}, halfSel};
      OP_LHU:  extData = {16'h0, halfSel};
      default: extData = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// rtl/data_mem_bridge.sv - M-stage load/store unit driving a req/addr_ok/data_ok SRAM-like data bus
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter bit MASK_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  input  logic        memvalidM,
  input  logic        pipe_stall,
  output logic [31:0] readdataM,
  output logic        adel_rdM,
  output logic        adesM,
  output logic        stallM,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  memState_t   state, stateNext;
  logic        isLoad, isStore, memOp, mis, acc;
  logic [1:0]  mSize;
  logic [31:0] physAddr, laneData;
  logic [3:0]  laneStrb;
  logic [5:0]  opQ;
  logic [31:0] addrQ, wdataQ, rdQ, extData;
  logic [3:0]  wstrbQ;
  logic [1:0]  sizeQ;
  logic        cancelQ, capture, loadRd, liveLoad;

  always_comb begin
    isLoad  = isLoadOp(opM);
    isStore = isStoreOp(opM);
    memOp   = isLoad | isStore;
    mSize   = opSize(opM);
    mis     = memOp & (((mSize == SZ_WORD) & (|aluoutM[1:0])) |
                       ((mSize == SZ_HALF) & aluoutM[0]));
    adel_rdM = memvalidM & isLoad & mis;
    adesM    = memvalidM & isStore & mis;
    // Gating with rst keeps the bus quiet while reset is held.
    acc      = rst & memvalidM & memOp & ~mis;
    physAddr = (MASK_KSEG && (aluoutM[31:30] == 2'b10)) ? {3'b000, aluoutM[28:0]} : aluoutM;
    laneStrb = 4'b0000;
    laneData = writedataM;
    if (isStore) begin
      case (mSize)
        SZ_BYTE: begin
          laneStrb = 4'b0001 << aluoutM[1:0];
          laneData = {4{writedataM[7:0]}};
        end
        SZ_HALF: begin
          laneStrb = aluoutM[1] ? 4'b1100 : 4'b0011;
          laneData = {2{writedataM[15:0]}};
        end
        default: laneStrb = 4'b1111;
      endcase
    end
  end

  mem_load_ext uExt (
    .op      (opQ),
    .addrLo  (addrQ[1:0]),
    .rdata   (data_rdata),
    .extData (extData)
  );

  always_comb begin
    stateNext  = state;
    capture    = 1'b0;
    loadRd     = 1'b0;
    liveLoad   = 1'b0;
    stallM     = 1'b0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = sizeQ;
    data_addr  = addrQ;
    data_wstrb = wstrbQ;
    data_wdata = wdataQ;
    case (state)
      IDLE: begin
        data_req   = acc;
        data_wr    = acc & isStore;
        data_size  = mSize;
        data_addr  = physAddr;
        data_wstrb = laneStrb;
        data_wdata = laneData;
        stallM     = acc;
        if (acc) begin
          capture   = 1'b1;
          stateNext = data_addr_ok ? WAIT : REQ;
        end
      end
      REQ: begin
        data_req = 1'b1;
        data_wr  = isStoreOp(opQ);
        stallM   = cancelQ ? acc : 1'b1;
        if (data_addr_ok) stateNext = WAIT;
      end
      WAIT: begin
        // A cancelled transaction only holds back whatever new access M now carries.
        stallM = cancelQ ? acc : ~data_data_ok;
        if (data_data_ok) begin
          if (cancelQ) begin
            stateNext = IDLE;
          end else begin
            liveLoad  = isLoadOp(opQ);
            loadRd    = liveLoad;
            stateNext = pipe_stall ? DONE : IDLE;
          end
        end
      end
      DONE: begin
        if (!pipe_stall) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign readdataM = liveLoad ? extData : rdQ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      opQ     <= '0;
      addrQ   <= '0;
      wdataQ  <= '0;
      wstrbQ  <= '0;
      sizeQ   <= '0;
      rdQ     <= '0;
      cancelQ <= 1'b0;
    end else begin
      state <= stateNext;
      if (capture) begin
        opQ    <= opM;
        addrQ  <= physAddr;
        wdataQ <= laneData;
        wstrbQ <= laneStrb;
        sizeQ  <= mSize;
      end
      if (loadRd) rdQ <= extData;
      if (stateNext == IDLE)
        cancelQ <= 1'b0;
      else if (((state == REQ) || (state == WAIT)) && !memvalidM)
        cancelQ <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// tb/tb_data_mem_bridge.sv - scoreboard bench for data_mem_bridge with directed bus timing vectors
module tb_data_mem_bridge;
  import data_mem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  opM = '0;
  logic [31:0] aluoutM = '0, writedataM = '0;
  logic        memvalidM = 1'b0, pipe_stall = 1'b0;
  logic [31:0] readdataM;
  logic        adel_rdM, adesM, stallM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;

  data_mem_bridge #(.MASK_KSEG(1'b1)) dut (
    .clk(clk), .rst(rst), .opM(opM), .aluoutM(aluoutM), .writedataM(writedataM),
    .memvalidM(memvalidM), .pipe_stall(pipe_stall), .readdataM(readdataM),
    .adel_rdM(adel_rdM), .adesM(adesM), .stallM(stallM), .data_req(data_req),
    .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic wr; logic [1:0] size; logic [31:0] addr; logic [3:0] wstrb; logic [31:0] wdata; logic chkData;
  } reqExp_t;
  typedef struct { logic chk; logic [31:0] val; } rdExp_t;
  typedef struct {
    logic [5:0] op; logic st; logic [31:0] va, wd; int aw, dw; logic [31:0] rdata;
    logic [1:0] sz; logic [31:0] pa; logic [3:0] strb; logic [31:0] wdata, rd;
  } vec_t;

  reqExp_t reqQ[$];
  rdExp_t  rdQ[$];
  int nChecks = 0, nErrors = 0, reqCnt = 0, stallCnt = 0;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic reqExp_t mkReq(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                    input logic [3:0] st, input logic [31:0] wd, input logic cd);
    reqExp_t r;
    r.wr = wr; r.size = sz; r.addr = a; r.wstrb = st; r.wdata = wd; r.chkData = cd;
    return r;
  endfunction

  function automatic rdExp_t mkRd(input logic chk, input logic [31:0] val);
    rdExp_t r;
    r.chk = chk; r.val = val;
    return r;
  endfunction

  // Monitor: every request cycle is compared with the oldest expected request.
  always @(negedge clk) begin
    rdExp_t e;
    if (rst) begin
      if (data_req) begin
        reqCnt++;
        if (reqQ.size() == 0) begin
          nChecks++; nErrors++;
          $display("FAIL unexpected_req: got req at addr 0x%08h, expected no request", data_addr);
        end else begin
          check("req_wr", 32'(data_wr), 32'(reqQ[0].wr));
          check("req_size", 32'(data_size), 32'(reqQ[0].size));
          check("req_addr", data_addr, reqQ[0].addr);
          check("req_wstrb", 32'(data_wstrb), 32'(reqQ[0].wstrb));
          if (reqQ[0].chkData) check("req_wdata", data_wdata, reqQ[0].wdata);
          if (data_addr_ok) void'(reqQ.pop_front());
        end
      end
      if (data_data_ok) begin
        if (rdQ.size() == 0) begin
          nChecks++; nErrors++;
          $display("FAIL unexpected_data_ok: got data_ok, expected no outstanding transaction");
        end else begin
          e = rdQ.pop_front();
          if (e.chk) check("readdataM", readdataM, e.val);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    if (stallM) stallCnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic runAccess(input vec_t v, input logic ps, input string name);
    reqQ.push_back(mkReq(v.st, v.sz, v.pa, v.strb, v.wdata, v.st));
    rdQ.push_back(mkRd(~v.st, v.rd));
    stallCnt = 0; reqCnt = 0;
    opM = v.op; aluoutM = v.va; writedataM = v.wd; memvalidM = 1'b1; pipe_stall = 1'b0;
    data_addr_ok = 1'b0;
    for (int i = 0; i < v.aw; i++) cyc();
    data_addr_ok = 1'b1;
    cyc();
    data_addr_ok = 1'b0;
    for (int i = 0; i < v.dw; i++) cyc();
    data_data_ok = 1'b1; data_rdata = v.rdata; pipe_stall = ps;
    cyc();
    data_data_ok = 1'b0; data_rdata = '0;
    if (!ps) memvalidM = 1'b0;
    check({name, "_stall_cycles"}, 32'(stallCnt), 32'(v.aw + 1 + v.dw));
    check({name, "_req_cycles"}, 32'(reqCnt), 32'(v.aw + 1));
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{OP_LW,  1'b0, 32'h8000_0010, 32'h0, 0, 2, 32'h1234_5678, SZ_WORD, 32'h0000_0010, 4'b0000, 32'h0, 32'h1234_5678};
    vecs[1] = '{OP_LB,  1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_0000, SZ_BYTE, 32'h0000_1003, 4'b0000, 32'h0, 32'hFFFF_FF80};
    vecs[2] = '{OP_LBU, 1'b0, 32'h0000_1003, 32'h0, 0, 0, 32'h80FF_0000, SZ_BYTE, 32'h0000_1003, 4'b0000, 32'h0, 32'h0000_0080};
    vecs[3] = '{OP_LH,  1'b0, 32'h0000_1002, 32'h0, 0, 0, 32'h80FF_0000, SZ_HALF, 32'h0000_1002, 4'b0000, 32'h0, 32'hFFFF_80FF};
    vecs[4] = '{OP_LHU, 1'b0, 32'h0000_2002, 32'h0, 2, 1, 32'h9ABC_1234, SZ_HALF, 32'h0000_2002, 4'b0000, 32'h0, 32'h0000_9ABC};
    vecs[5] = '{OP_SH,  1'b1, 32'hA000_0102, 32'hAAAA_BEEF, 3, 0, 32'h0, SZ_HALF, 32'h0000_0102, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[6] = '{OP_SB,  1'b1, 32'h4000_0001, 32'h1234_56A5, 1, 1, 32'h0, SZ_BYTE, 32'h4000_0001, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vecs[7] = '{OP_SW,  1'b1, 32'hC000_0008, 32'hDEAD_BEEF, 0, 0, 32'h0, SZ_WORD, 32'hC000_0008, 4'b1111, 32'hDEAD_BEEF, 32'h0};

    // Reset values, with a live store presented while reset is held
    opM = OP_SW; aluoutM = 32'h100; memvalidM = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_req", 32'(data_req), 32'h0);
    check("rst_data_wr", 32'(data_wr), 32'h0);
    check("rst_stallM", 32'(stallM), 32'h0);
    check("rst_readdataM", readdataM, 32'h0);
    memvalidM = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    cyc();

    foreach (vecs[i]) begin
      runAccess(vecs[i], 1'b0, $sformatf("vec%0d", i));
      cyc();
    end
    @(negedge clk);
    check("rd_hold_after_stores", readdataM, 32'h0000_9ABC);
    @(posedge clk);
    #1;

    // Address errors: {op, addr, valid, adel, ades}
    for (int i = 0; i < 4; i++) begin
      logic [5:0] eop; logic [31:0] ea; logic ev, eadel, eades;
      case (i)
        0: begin eop = OP_LW;  ea = 32'h1002; ev = 1'b1; eadel = 1'b1; eades = 1'b0; end
        1: begin eop = OP_SH;  ea = 32'h1001; ev = 1'b1; eadel = 1'b0; eades = 1'b1; end
        2: begin eop = OP_LHU; ea = 32'h1003; ev = 1'b1; eadel = 1'b1; eades = 1'b0; end
        default: begin eop = OP_LW; ea = 32'h1002; ev = 1'b0; eadel = 1'b0; eades = 1'b0; end
      endcase
      opM = eop; aluoutM = ea; memvalidM = ev;
      @(negedge clk);
      check($sformatf("aerr%0d_adel", i), 32'(adel_rdM), 32'(eadel));
      check($sformatf("aerr%0d_ades", i), 32'(adesM), 32'(eades));
      check($sformatf("aerr%0d_req", i), 32'(data_req), 32'h0);
      check($sformatf("aerr%0d_stall", i), 32'(stallM), 32'h0);
      @(posedge clk);
      #1;
    end
    memvalidM = 1'b0;
    cyc();

    // Flush during WAIT with a new LW waiting behind it
    reqQ.push_back(mkReq(1'b0, SZ_WORD, 32'h1000, 4'b0000, 32'h0, 1'b0));
    rdQ.push_back(mkRd(1'b1, 32'h0000_9ABC));
    opM = OP_LW; aluoutM = 32'h1000; memvalidM = 1'b1; data_addr_ok = 1'b1;
    @(negedge clk); check("cancel_issue_stall", 32'(stallM), 32'h1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0; memvalidM = 1'b0;
    @(negedge clk); check("cancel_flush_stall", 32'(stallM), 32'h1);
    @(posedge clk); #1;
    aluoutM = 32'h2004; memvalidM = 1'b1;
    reqQ.push_back(mkReq(1'b0, SZ_WORD, 32'h2004, 4'b0000, 32'h0, 1'b0));
    @(negedge clk);
    check("cancel_wait_stall", 32'(stallM), 32'h1);
    check("cancel_wait_noreq", 32'(data_req), 32'h0);
    @(posedge clk); #1;
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_0000;
    @(negedge clk);
    check("cancel_dok_stall", 32'(stallM), 32'h1);
    check("cancel_dok_noreq", 32'(data_req), 32'h0);
    check("cancel_dok_rd", readdataM, 32'h0000_9ABC);
    @(posedge clk); #1;
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    rdQ.push_back(mkRd(1'b1, 32'h0BAD_F00D));
    @(negedge clk);
    check("newlw_req", 32'(data_req), 32'h1);
    check("newlw_stall", 32'(stallM), 32'h1);
    @(posedge clk); #1;
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    @(negedge clk); check("newlw_dok_stall", 32'(stallM), 32'h0);
    @(posedge clk); #1;
    data_data_ok = 1'b0; memvalidM = 1'b0;
    cyc();

    // pipe_stall at data_ok parks the result in DONE
    v = '{OP_LW, 1'b0, 32'h0000_3000, 32'h0, 0, 1, 32'hCAFE_0001, SZ_WORD, 32'h0000_3000, 4'b0000, 32'h0, 32'hCAFE_0001};
    runAccess(v, 1'b1, "pstall");
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pipe_stall = 1'b0;
      @(negedge clk);
      check($sformatf("done%0d_noreq", i), 32'(data_req), 32'h0);
      check($sformatf("done%0d_stall", i), 32'(stallM), 32'h0);
      check($sformatf("done%0d_rd", i), readdataM, 32'hCAFE_0001);
      @(posedge clk); #1;
    end
    memvalidM = 1'b0;
    @(negedge clk); check("idle_rd_hold", readdataM, 32'hCAFE_0001);
    @(posedge clk); #1;
    v = '{OP_LBU, 1'b0, 32'h0000_3001, 32'h0, 0, 0, 32'h0000_AB00, SZ_BYTE, 32'h0000_3001, 4'b0000, 32'h0, 32'h0000_00AB};
    runAccess(v, 1'b0, "after_done");
    cyc();

    // Reset asserted while WAIT is outstanding
    reqQ.push_back(mkReq(1'b0, SZ_WORD, 32'h4000, 4'b0000, 32'h0, 1'b0));
    opM = OP_LW; aluoutM = 32'h4000; memvalidM = 1'b1; data_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_addr_ok = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("wrst_req", 32'(data_req), 32'h0);
    check("wrst_stall", 32'(stallM), 32'h0);
    check("wrst_rd", readdataM, 32'h0);
    check("wrst_state", 32'(dut.state), 32'(IDLE));
    @(negedge clk);
    memvalidM = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_req", 32'(data_req), 32'h0);
    @(posedge clk); #1;

    check("reqQ_drained", 32'(reqQ.size()), 32'h0);
    check("rdQ_drained", 32'(rdQ.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected $finish");
    $fatal(1);
  end

endmodule
